// File: rtl/cpu_host_pkg.sv
// Shared definitions for the host command controller: opcodes, status-word
// field positions and FSM state encoding.
package cpu_host_pkg;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_PRST = 4'h1;
  localparam logic [3:0] OP_IWR  = 4'h2;
  localparam logic [3:0] OP_IRD  = 4'h3;
  localparam logic [3:0] OP_DWR  = 4'h4;
  localparam logic [3:0] OP_DRD  = 4'h6;
  localparam logic [3:0] OP_RUN  = 4'h8;

  localparam int ST_RUNNING_BIT = 31;
  localparam int ST_BUSY_BIT    = 30;
  localparam int ST_ERR_BIT     = 29;
  localparam int ST_OP_LSB      = 24;
  localparam int ST_CNT_W       = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRST,
    S_WR,
    S_RD,
    S_RUN
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_HALT, OP_PRST, OP_IWR, OP_IRD, OP_DWR, OP_DRD, OP_RUN: op_legal = 1'b1;
      default:                                                 op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/host_cmd_decode.sv
// Registers the host command word and flags a new command whenever the word
// changes while the controller is able to take it.
module host_cmd_decode
  import cpu_host_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd_in,
  input  logic        can_accept,
  output logic        accept,
  output logic [3:0]  opcode,
  output logic [27:0] arg,
  output logic        legal
);

  logic [31:0] cmd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cmd_q <= '0;
    else      cmd_q <= cmd_in;
  end

  // Changes seen while the controller is busy are dropped, not deferred.
  assign accept = can_accept && (cmd_in != cmd_q);
  assign opcode = cmd_in[31:28];
  assign arg    = cmd_in[27:0];
  assign legal  = op_legal(cmd_in[31:28]);

endmodule

// File: rtl/cpu_host_ctrl.sv
// Host command controller: sequences CPU pipeline reset, run/halt and
// host-side memory access (memory access only while halted).
module cpu_host_ctrl
  import cpu_host_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int RST_CYCLES = 4,
  parameter int RD_LAT     = 1,
  parameter int CNT_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cmd_in,
  input  logic [31:0]       din_low,
  input  logic [31:0]       din_high,
  output logic [31:0]       cmd_out,
  output logic [31:0]       dout_low,
  output logic [31:0]       dout_high,
  output logic              pipe_en,
  output logic              pipe_rst,
  output logic              mem_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int RL_W = $clog2(RD_LAT + 1);

  state_t             state;
  logic               accept;
  logic               legal;
  logic [3:0]         opcode;
  logic [27:0]        arg;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   remain;
  logic [RC_W-1:0]    rst_cnt;
  logic [RL_W-1:0]    rd_cnt;
  logic               err;
  logic [3:0]         last_op;
  logic               unused_arg_bits;

  host_cmd_decode u_decode (
    .clk        (clk),
    .rst        (rst),
    .cmd_in     (cmd_in),
    .can_accept (state == S_IDLE || state == S_RUN),
    .accept     (accept),
    .opcode     (opcode),
    .arg        (arg),
    .legal      (legal)
  );

  assign unused_arg_bits = ^arg[27:CNT_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pipe_en   <= 1'b0;
      pipe_rst  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      count     <= '0;
      remain    <= '0;
      rst_cnt   <= '0;
      rd_cnt    <= '0;
      err       <= 1'b0;
      last_op   <= '0;
      dout_low  <= '0;
      dout_high <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (accept) last_op <= opcode;
      if (accept && !legal) err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (accept && legal) begin
            case (opcode)
              OP_PRST: begin
                state    <= S_PRST;
                pipe_rst <= 1'b1;
                rst_cnt  <= RC_W'(RST_CYCLES - 1);
                count    <= '0;
                err      <= 1'b0;
              end
              OP_DWR, OP_IWR: begin
                state    <= S_WR;
                mem_en   <= 1'b1;
                mem_we   <= 1'b1;
                mem_sel  <= (opcode == OP_IWR);
                mem_addr <= arg[ADDR_W-1:0];
              end
              OP_DRD, OP_IRD: begin
                state    <= S_RD;
                mem_en   <= 1'b1;
                mem_sel  <= (opcode == OP_IRD);
                mem_addr <= arg[ADDR_W-1:0];
                rd_cnt   <= '0;
              end
              OP_RUN: begin
                state   <= S_RUN;
                pipe_en <= 1'b1;
                remain  <= arg[CNT_W-1:0];
              end
              default: ;
            endcase
          end
        end

        S_PRST: begin
          if (rst_cnt == '0) begin
            pipe_rst <= 1'b0;
            state    <= S_IDLE;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end

        S_WR: state <= S_IDLE;

        S_RD: begin
          if (rd_cnt == RL_W'(RD_LAT)) begin
            {dout_high, dout_low} <= mem_rdata;
            state                 <= S_IDLE;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (count != '1) count <= count + 1'b1;
          // A zero run length means run until an explicit HALT.
          if (accept && legal && opcode == OP_PRST) begin
            state    <= S_PRST;
            pipe_en  <= 1'b0;
            pipe_rst <= 1'b1;
            rst_cnt  <= RC_W'(RST_CYCLES - 1);
            count    <= '0;
            err      <= 1'b0;
          end else if (accept && legal && opcode == OP_HALT) begin
            state   <= S_IDLE;
            pipe_en <= 1'b0;
          end else if (accept && legal && opcode == OP_RUN) begin
            remain <= arg[CNT_W-1:0];
          end else begin
            if (accept && legal) err <= 1'b1;
            if (remain == CNT_W'(1)) begin
              state   <= S_IDLE;
              pipe_en <= 1'b0;
              remain  <= '0;
            end else if (remain != '0) begin
              remain <= remain - 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Write data follows din during the access cycle so it is sampled there.
  assign mem_wdata = mem_we ? {din_high, din_low} : 64'h0;

  always_comb begin
    cmd_out                                  = '0;
    cmd_out[ST_RUNNING_BIT]                  = (state == S_RUN);
    cmd_out[ST_BUSY_BIT]                     = (state == S_PRST) || (state == S_WR) || (state == S_RD);
    cmd_out[ST_ERR_BIT]                      = err;
    cmd_out[ST_OP_LSB+3:ST_OP_LSB]           = last_op;
    cmd_out[ST_CNT_W-1:0]                    = ST_CNT_W'(count);
  end

endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Scoreboard bench for cpu_host_ctrl: directed commands push expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_cpu_host_ctrl;

  localparam int EV_WR   = 0;
  localparam int EV_RD   = 1;
  localparam int EV_DOUT = 2;
  localparam int EV_PRST = 3;
  localparam int EV_RUN  = 4;

  typedef struct {
    int           kind;
    logic [127:0] exp;
    string        name;
  } sb_entry_t;

  logic        clk;
  logic        rst;
  logic [31:0] cmd_in;
  logic [31:0] din_low;
  logic [31:0] din_high;
  logic [31:0] cmd_out;
  logic [31:0] dout_low;
  logic [31:0] dout_high;
  logic        pipe_en;
  logic        pipe_rst;
  logic        mem_sel;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  logic [63:0] mem_model [0:2047];
  sb_entry_t   sb_q[$];
  int          tests_run;
  int          fails;

  cpu_host_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_in    (cmd_in),
    .din_low   (din_low),
    .din_high  (din_high),
    .cmd_out   (cmd_out),
    .dout_low  (dout_low),
    .dout_high (dout_high),
    .pipe_en   (pipe_en),
    .pipe_rst  (pipe_rst),
    .mem_sel   (mem_sel),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one cycle of read latency.
  initial begin
    for (int i = 0; i < 2048; i++) mem_model[i] = 64'h0;
    mem_rdata = 64'h0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[{mem_sel, mem_addr}] <= mem_wdata;
      else        mem_rdata <= mem_model[{mem_sel, mem_addr}];
    end
  end

  task automatic applyStimulus(input logic [31:0] cmd);
    @(negedge clk);
    cmd_in = cmd;
  endtask

  task automatic expectEvent(input int kind, input logic [127:0] exp, input string name);
    sb_entry_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic scoreEvent(input int kind, input logic [127:0] act);
    sb_entry_t e;
    tests_run++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL unexpected_event kind %0d: got %h, expected no event", kind, act);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.exp !== act) begin
        fails++;
        $display("[TB] FAIL %s: got kind %0d value %h, expected kind %0d value %h",
                 e.name, kind, act, e.kind, e.exp);
      end
    end
  endtask

  // Monitor: turns DUT output activity into scoreboard events.
  initial begin
    int          run_len;
    int          rst_len;
    int          rd_t;
    logic        prev_pipe_en;
    logic        prev_pipe_rst;
    logic [63:0] prev_dout;
    run_len = 0; rst_len = 0; rd_t = -1;
    prev_pipe_en = 1'b0; prev_pipe_rst = 1'b0; prev_dout = 64'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pipe_en) run_len++;
        if (!pipe_en && prev_pipe_en) begin
          scoreEvent(EV_RUN, {32'(run_len), cmd_out});
          run_len = 0;
        end
        if (pipe_rst) rst_len++;
        if (!pipe_rst && prev_pipe_rst) begin
          scoreEvent(EV_PRST, {32'(rst_len), cmd_out});
          rst_len = 0;
        end
        if (mem_en && mem_we) scoreEvent(EV_WR, 128'({mem_sel, mem_addr, mem_wdata}));
        if (mem_en && !mem_we) begin
          scoreEvent(EV_RD, 128'({mem_sel, mem_addr}));
          rd_t = 0;
        end else if (rd_t >= 0) begin
          rd_t++;
        end
        if ({dout_high, dout_low} != prev_dout)
          scoreEvent(EV_DOUT, {32'(rd_t), dout_high, dout_low});
      end else begin
        run_len = 0;
        rst_len = 0;
        rd_t    = -1;
      end
      prev_pipe_en  = pipe_en;
      prev_pipe_rst = pipe_rst;
      prev_dout     = {dout_high, dout_low};
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run = 0;
    fails     = 0;
    rst       = 1'b0;
    cmd_in    = 32'h0;
    din_low   = 32'h0;
    din_high  = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_status", {cmd_out, dout_high, dout_low}, 96'h0);
    checkOutput("reset_ctrl", {pipe_en, pipe_rst, mem_en, mem_we, mem_sel, mem_addr}, 15'h0);
    checkOutput("reset_wdata", mem_wdata, 64'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Illegal opcode while idle: err set, last opcode recorded.
    applyStimulus(32'h5000_0000);
    @(negedge clk);
    checkOutput("illegal_idle", cmd_out, 32'h2500_0000);

    // Pipeline reset: 4-cycle pulse, busy while active, err cleared.
    expectEvent(EV_PRST, {32'd4, 32'h0100_0000}, "prst_pulse");
    applyStimulus(32'h1000_0000);
    @(negedge clk);
    checkOutput("prst_busy", {pipe_rst, cmd_out}, {1'b1, 32'h4100_0000});
    repeat (6) @(negedge clk);

    // Data write: din changed after acceptance must be what gets written.
    din_low  = 32'h99;
    din_high = 32'h0;
    expectEvent(EV_WR, 128'({1'b0, 10'h049, 64'h5}), "dwr_access");
    applyStimulus(32'h4000_0049);
    @(posedge clk);
    #1 din_low = 32'h5;
    repeat (4) @(negedge clk);

    expectEvent(EV_RD, 128'({1'b0, 10'h049}), "drd_strobe");
    expectEvent(EV_DOUT, {32'd2, 64'h5}, "drd_data");
    applyStimulus(32'h6000_0049);
    repeat (5) @(negedge clk);
    checkOutput("drd_idle", {cmd_out[30], dout_low}, {1'b0, 32'h5});

    // Instruction memory at the same address must stay separate.
    din_low  = 32'h1234_5678;
    din_high = 32'h9ABC_DEF0;
    expectEvent(EV_WR, 128'({1'b1, 10'h049, 64'h9ABC_DEF0_1234_5678}), "iwr_access");
    applyStimulus(32'h2000_0049);
    repeat (4) @(negedge clk);
    expectEvent(EV_RD, 128'({1'b1, 10'h049}), "ird_strobe");
    expectEvent(EV_DOUT, {32'd2, 64'h9ABC_DEF0_1234_5678}, "ird_data");
    applyStimulus(32'h3000_0049);
    repeat (5) @(negedge clk);
    expectEvent(EV_RD, 128'({1'b0, 10'h049}), "drd2_strobe");
    expectEvent(EV_DOUT, {32'd2, 64'h5}, "drd2_data");
    applyStimulus(32'h6000_0049);
    repeat (5) @(negedge clk);

    // Unbounded run halted after 650 cycles.
    expectEvent(EV_RUN, {32'd650, 32'h0000_028A}, "run_unbounded");
    applyStimulus(32'h8000_0000);
    @(negedge clk);
    checkOutput("run_active", {pipe_en, cmd_out[31:30]}, 3'b110);
    repeat (649) @(posedge clk);
    applyStimulus(32'h0000_0000);
    repeat (3) @(negedge clk);

    expectEvent(EV_PRST, {32'd4, 32'h0100_0000}, "prst_clear_count");
    applyStimulus(32'h1000_0000);
    repeat (6) @(negedge clk);

    // Bounded run of 16 cycles ends on its own.
    expectEvent(EV_RUN, {32'd16, 32'h0800_0010}, "run_bounded");
    applyStimulus(32'h8000_0010);
    repeat (22) @(negedge clk);

    // Memory access during run is refused and flagged; counter keeps going.
    expectEvent(EV_RUN, {32'd13, 32'h2000_001D}, "run_illegal_halt");
    applyStimulus(32'h8000_0000);
    repeat (10) @(posedge clk);
    applyStimulus(32'h6000_0049);
    repeat (2) @(negedge clk);
    checkOutput("run_illegal_access", {cmd_out[31:29], mem_en}, 4'b1010);
    applyStimulus(32'h0000_0000);
    repeat (3) @(negedge clk);

    expectEvent(EV_PRST, {32'd4, 32'h0100_0000}, "prst_clear_err");
    applyStimulus(32'h1000_0000);
    repeat (6) @(negedge clk);
    checkOutput("err_cleared", cmd_out[29], 1'b0);

    // Async reset during the write access cycle aborts the write.
    din_low = 32'h7;
    applyStimulus(32'h4000_0077);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_midwr_ctrl", {mem_en, mem_we, pipe_en, pipe_rst, mem_sel, mem_addr}, 15'h0);
    checkOutput("rst_midwr_data", {mem_wdata, cmd_out, dout_low}, 128'h0);
    checkOutput("rst_midwr_douth", dout_high, 32'h0);
    cmd_in = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_midwr_nowrite", mem_model[{1'b0, 10'h077}], 64'h0);
    checkOutput("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
